// File: rtl/fsm_step_controller.sv
// Step/load/run sequencer for the 3-bit state counter: debounced buttons drive a
// PAUSE/RUN/LOAD machine that emits registered step and load strobes.
module fsm_step_controller #(
   parameter int DIV = 50_000_000,
   parameter int DEB = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_load,
   input  logic key_run,
   input  logic key_step,
   output logic step_en,
   output logic load,
   output logic running
);

   localparam int PW = $clog2(DIV);
   localparam int CW = $clog2(DEB + 1);

   localparam logic [1:0] ST_PAUSE = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;

   // Key vector order: bit 0 load, bit 1 run, bit 2 step.
   logic [2:0]    keys;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    db;
   logic [2:0]    db_q;
   logic [CW-1:0] deb_cnt [3];
   logic [2:0]    press;

   logic [1:0]    state;
   logic          ret;
   logic [PW-1:0] presc;

   assign keys  = {key_step, key_run, key_load};
   assign press = db & ~db_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         db_q  <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= keys;
         sync2 <= sync1;
         db_q  <= db;
         // A level change is accepted only after DEB consecutive mismatching cycles.
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == db[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CW'(DEB)) begin
               db[i]      <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_PAUSE;
         ret     <= 1'b0;
         presc   <= '0;
         step_en <= 1'b0;
         load    <= 1'b0;
         running <= 1'b0;
      end else begin
         step_en <= 1'b0;
         load    <= 1'b0;
         case (state)
            ST_PAUSE: begin
               presc <= '0;
               if (press[0]) begin
                  state   <= ST_LOAD;
                  ret     <= 1'b0;
                  load    <= 1'b1;
                  running <= 1'b0;
               end else if (press[1]) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end else if (press[2]) begin
                  step_en <= 1'b1;
               end
            end
            ST_RUN: begin
               // Load and run presses win over a coinciding prescaler wrap.
               if (press[0]) begin
                  state   <= ST_LOAD;
                  ret     <= 1'b1;
                  load    <= 1'b1;
                  running <= 1'b1;
                  presc   <= '0;
               end else if (press[1]) begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
                  presc   <= '0;
               end else if (presc == PW'(DIV - 1)) begin
                  presc   <= '0;
                  step_en <= 1'b1;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            ST_LOAD: begin
               presc   <= '0;
               state   <= ret ? ST_RUN : ST_PAUSE;
               running <= ret;
            end
            default: begin
               state   <= ST_PAUSE;
               presc   <= '0;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_step_controller.sv
// Bench for fsm_step_controller: directed scenarios plus random key activity,
// all checked cycle by cycle against a behavioural model of the button/step rules.
module tb_fsm_step_controller;

   localparam int DIV = 5;
   localparam int DEB = 4;

   localparam int M_PAUSE = 0;
   localparam int M_RUN   = 1;
   localparam int M_LOAD  = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic key_load = 1'b1;
   logic key_run = 1'b1;
   logic key_step = 1'b1;
   logic step_en;
   logic load;
   logic running;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b1;

   fsm_step_controller #(.DIV(DIV), .DEB(DEB)) dut (
      .clk(clk),
      .reset(reset),
      .key_load(key_load),
      .key_run(key_run),
      .key_step(key_step),
      .step_en(step_en),
      .load(load),
      .running(running)
   );

   always #5 clk = ~clk;

   // Behavioural model: synchronizer delay, run-length debounce, press = new accepted
   // high level, and a mode/run-length description of the sequencing rules.
   bit m_s1 [3];
   bit m_s [3];
   bit m_db [3];
   bit m_dbq [3];
   int m_dlen [3];
   bit m_press [3];
   bit m_key [3];
   int mode = M_PAUSE;
   bit ret_run = 1'b0;
   int run_len = 0;
   bit e_step = 1'b0;
   bit e_load = 1'b0;
   bit e_run = 1'b0;

   always @(posedge clk) begin
      m_key[0] = key_load;
      m_key[1] = key_run;
      m_key[2] = key_step;
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            m_s1[i] = 0; m_s[i] = 0; m_db[i] = 0; m_dbq[i] = 0; m_dlen[i] = 0;
         end
         mode = M_PAUSE; ret_run = 0; run_len = 0;
         e_step = 0; e_load = 0; e_run = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            m_press[i] = m_db[i] && !m_dbq[i];
            m_dbq[i] = m_db[i];
            if (m_s[i] != m_db[i]) begin
               m_dlen[i]++;
               if (m_dlen[i] > DEB) begin
                  m_db[i] = m_s[i];
                  m_dlen[i] = 0;
               end
            end else begin
               m_dlen[i] = 0;
            end
            m_s[i] = m_s1[i];
            m_s1[i] = m_key[i];
         end
         e_step = 0;
         e_load = 0;
         if (mode == M_PAUSE) begin
            if (m_press[0]) begin mode = M_LOAD; ret_run = 0; e_load = 1; end
            else if (m_press[1]) begin mode = M_RUN; run_len = 0; end
            else if (m_press[2]) e_step = 1;
         end else if (mode == M_RUN) begin
            if (m_press[0]) begin mode = M_LOAD; ret_run = 1; e_load = 1; end
            else if (m_press[1]) mode = M_PAUSE;
            else begin
               run_len++;
               e_step = (run_len % DIV) == 0;
            end
         end else begin
            mode = ret_run ? M_RUN : M_PAUSE;
            run_len = 0;
         end
         e_run = (mode == M_RUN) || (mode == M_LOAD && ret_run);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         checks++;
         assert (step_en === e_step) else begin
            failures++;
            $error("FAIL step_en observed=%0b expected=%0b t=%0t", step_en, e_step, $time);
         end
         checks++;
         assert (load === e_load) else begin
            failures++;
            $error("FAIL load observed=%0b expected=%0b t=%0t", load, e_load, $time);
         end
         checks++;
         assert (running === e_run) else begin
            failures++;
            $error("FAIL running observed=%0b expected=%0b t=%0t", running, e_run, $time);
         end
         checks++;
         assert (!(step_en === 1'b1 && load === 1'b1)) else begin
            failures++;
            $error("FAIL exclusive observed=step_en&load expected=never t=%0t", $time);
         end
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Applies the given inputs for n cycles and counts output highs seen meanwhile.
   task automatic drive(input logic r, input logic kl, input logic kr, input logic ks,
                        input int n, output int ns, output int nl, output int nr);
      reset = r; key_load = kl; key_run = kr; key_step = ks;
      ns = 0; nl = 0; nr = 0;
      repeat (n) begin
         @(negedge clk);
         if (step_en === 1'b1) ns++;
         if (load === 1'b1) nl++;
         if (running === 1'b1) nr++;
      end
   endtask

   initial begin
      int ns, nl, nr, ns2, nl2, nr2;

      // Reset with all keys held, then quiet after release.
      drive(1, 1, 1, 1, 3, ns, nl, nr);
      chk("reset_outputs", ns + nl + nr, 0);
      drive(0, 0, 0, 0, 20, ns, nl, nr);
      chk("idle_step", ns, 0);
      chk("idle_load", nl, 0);
      chk("idle_running", nr, 0);

      // Run: running from press edge 7, steps every DIV cycles, then pause.
      drive(0, 0, 1, 0, 10, ns, nl, nr);
      chk("run_press_running", nr, 3);
      chk("run_press_step", ns, 0);
      drive(0, 0, 0, 0, 18, ns, nl, nr);
      chk("run_steps", ns, 4);
      chk("run_running", nr, 18);
      drive(0, 0, 1, 0, 10, ns, nl, nr);
      chk("pause_press_step", ns, 1);
      chk("pause_press_running", nr, 7);
      drive(0, 0, 0, 0, 20, ns, nl, nr);
      chk("paused_step", ns, 0);
      chk("paused_running", nr, 0);

      // Single step, then a short glitch.
      drive(0, 0, 0, 1, 10, ns, nl, nr);
      drive(0, 0, 0, 0, 10, ns2, nl2, nr2);
      chk("single_step", ns + ns2, 1);
      drive(0, 0, 0, 1, 3, ns, nl, nr);
      drive(0, 0, 0, 0, 12, ns2, nl2, nr2);
      chk("glitch_step", ns + ns2, 0);

      // Step press while running, then load from RUN.
      drive(0, 0, 1, 0, 10, ns, nl, nr);
      drive(0, 0, 0, 0, 3, ns, nl, nr);
      drive(0, 0, 0, 1, 10, ns, nl, nr);
      chk("run_step_ignored_running", nr, 10);
      drive(0, 1, 0, 0, 10, ns, nl, nr);
      drive(0, 0, 0, 0, 10, ns2, nl2, nr2);
      chk("load_in_run_count", nl + nl2, 1);
      chk("load_in_run_running", nr + nr2, 20);

      // Simultaneous load+run in PAUSE, then a fresh run press.
      drive(0, 0, 1, 0, 10, ns, nl, nr);
      drive(0, 0, 0, 0, 10, ns, nl, nr);
      chk("back_to_pause", nr, 0);
      drive(0, 1, 1, 0, 10, ns, nl, nr);
      drive(0, 0, 0, 0, 10, ns2, nl2, nr2);
      chk("simul_load", nl + nl2, 1);
      chk("simul_running", nr + nr2, 0);
      drive(0, 0, 1, 0, 10, ns, nl, nr);
      chk("repress_running", nr, 3);

      // Reset one cycle before the second scheduled step.
      drive(0, 0, 0, 0, 6, ns, nl, nr);
      chk("pre_reset_step", ns, 1);
      drive(1, 0, 0, 0, 1, ns, nl, nr);
      drive(0, 0, 0, 0, 10, ns2, nl2, nr2);
      chk("reset_abort_step", ns + ns2, 0);
      chk("reset_abort_running", nr + nr2, 0);
      drive(0, 0, 1, 0, 10, ns, nl, nr);
      drive(0, 0, 0, 0, 10, ns2, nl2, nr2);
      chk("restart_steps", ns + ns2, 2);

      // Random key activity and occasional resets, checked by the model.
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 39) == 0)
            drive(1, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), $urandom_range(1, 3), ns, nl, nr);
         else
            drive(0, logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 2) == 0), $urandom_range(1, 12), ns, nl, nr);
      end
      drive(0, 0, 0, 0, 20, ns, nl, nr);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
